// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / branch-operand hazard detection.
// Keeps EX and MEM destination tags and inserts bubbles while stalling.
module id_ex_hazard_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CTRL_WIDTH-1:0]     ctrl_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     rs_data_i,
  input  logic [DATA_WIDTH-1:0]     rt_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [5:0]                funct_i,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl_o,
  output logic [DATA_WIDTH-1:0]     ex_rs_data_o,
  output logic [DATA_WIDTH-1:0]     ex_rt_data_o,
  output logic [DATA_WIDTH-1:0]     ex_imm_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_dest_o,
  output logic [5:0]                ex_funct_o,
  output logic                      ex_valid_o,
  output logic                      stall_o,
  output logic [15:0]               stall_count_o
);

  logic                      mem_regwrite;
  logic                      mem_memread;
  logic [REG_ADDR_WIDTH-1:0] mem_dest;

  logic                      uses_rt;
  logic                      id_is_beq;
  logic                      ex_match;
  logic                      mem_match;
  logic [REG_ADDR_WIDTH-1:0] id_dest;

  always_comb begin
    uses_rt   = !ctrl_i[3] || ctrl_i[5];
    id_is_beq = (ctrl_i[2:1] == 2'b01);
    id_dest   = ctrl_i[0] ? rd_addr_i : rt_addr_i;

    ex_match  = ex_ctrl_o[7] && (ex_dest_o != '0) &&
                ((ex_dest_o == rs_addr_i) || (uses_rt && (ex_dest_o == rt_addr_i)));
    mem_match = mem_regwrite && (mem_dest != '0) &&
                ((mem_dest == rs_addr_i) || (uses_rt && (mem_dest == rt_addr_i)));

    stall_o = valid_i &&
              ((ex_ctrl_o[4] && ex_match) ||
               (id_is_beq && (ex_match || (mem_memread && mem_match))));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_ctrl_o    <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_addr_o <= '0;
      ex_rt_addr_o <= '0;
      ex_dest_o    <= '0;
      ex_funct_o   <= '0;
      ex_valid_o   <= 1'b0;
    end else if (stall_o) begin
      ex_ctrl_o    <= '0;
      ex_rs_data_o <= '0;
      ex_rt_data_o <= '0;
      ex_imm_o     <= '0;
      ex_rs_addr_o <= '0;
      ex_rt_addr_o <= '0;
      ex_dest_o    <= '0;
      ex_funct_o   <= '0;
      ex_valid_o   <= 1'b0;
    end else begin
      ex_ctrl_o    <= valid_i ? ctrl_i : '0;
      ex_rs_data_o <= rs_data_i;
      ex_rt_data_o <= rt_data_i;
      ex_imm_o     <= imm_i;
      ex_rs_addr_o <= rs_addr_i;
      ex_rt_addr_o <= rt_addr_i;
      ex_dest_o    <= id_dest;
      ex_funct_o   <= funct_i;
      ex_valid_o   <= valid_i;
    end
  end

  // MEM tag follows the EX tag unconditionally; bubbles arrive as zero tags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_dest     <= '0;
    end else begin
      mem_regwrite <= ex_ctrl_o[7];
      mem_memread  <= ex_ctrl_o[4];
      mem_dest     <= ex_dest_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_count_o <= '0;
    end else if (stall_o && (stall_count_o != '1)) begin
      stall_count_o <= stall_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: bubbles, stall lengths, async reset
// mid-stall and stall counter saturation.
`timescale 1ns/100ps
module tb_id_ex_hazard_stage;

  localparam logic [7:0] C_LW   = 8'hD8;
  localparam logic [7:0] C_ADD  = 8'hC5;
  localparam logic [7:0] C_SW   = 8'h28;
  localparam logic [7:0] C_BEQ  = 8'h02;
  localparam logic [7:0] C_ADDI = 8'h88;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ctrl = '0;
  logic        valid = 1'b0;
  logic [31:0] rs_data = '0, rt_data = '0, imm = '0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic [5:0]  funct = '0;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_dest;
  logic [5:0]  ex_funct;
  logic        ex_valid, stall;
  logic [15:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_hazard_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CTRL_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .valid_i(valid),
    .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr), .funct_i(funct),
    .ex_ctrl_o(ex_ctrl), .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data),
    .ex_imm_o(ex_imm), .ex_rs_addr_o(ex_rs_addr), .ex_rt_addr_o(ex_rt_addr),
    .ex_dest_o(ex_dest), .ex_funct_o(ex_funct), .ex_valid_o(ex_valid),
    .stall_o(stall), .stall_count_o(stall_count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one ID instruction; data fields are derived from the register indices.
  task automatic set_id(input logic [7:0] c, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    ctrl = c; valid = v; rs_addr = rs; rt_addr = rt; rd_addr = rd; funct = fn;
    rs_data = 32'hA000_0000 | {27'd0, rs};
    rt_data = 32'hB000_0000 | {27'd0, rt};
    imm     = 32'hFFFF_FF00 | {27'd0, rd};
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    set_id(8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 6'd0);
    chk("rst_ctrl", ex_ctrl, 8'h00);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_count", stall_count, 16'd0);
    step();
    rst = 1'b0;

    // lw $2,0($1) ; add $3,$2,$4 -> one stall
    set_id(C_LW, 1'b1, 5'd1, 5'd2, 5'd0, 6'd0);
    chk("lw_add_nostall0", stall, 1'b0);
    step();
    set_id(C_ADD, 1'b1, 5'd2, 5'd4, 5'd3, 6'h20);
    chk("lw_in_ex_ctrl", ex_ctrl, C_LW);
    chk("lw_in_ex_dest", ex_dest, 5'd2);
    chk("lw_add_stall", stall, 1'b1);
    step();
    chk("lw_add_bubble_ctrl", ex_ctrl, 8'h00);
    chk("lw_add_bubble_valid", ex_valid, 1'b0);
    chk("lw_add_bubble_data", ex_rs_data, 32'd0);
    chk("lw_add_bubble_dest", ex_dest, 5'd0);
    chk("lw_add_stall_end", stall, 1'b0);
    chk("lw_add_count", stall_count, 16'd1);
    step();
    chk("add_ex_ctrl", ex_ctrl, 8'b1_1_0_0_0_10_1);
    chk("add_ex_dest", ex_dest, 5'd3);
    chk("add_ex_rs_data", ex_rs_data, 32'hA000_0002);
    chk("add_ex_rt_data", ex_rt_data, 32'hB000_0004);
    chk("add_ex_imm", ex_imm, 32'hFFFF_FF03);
    chk("add_ex_rs_addr", ex_rs_addr, 5'd2);
    chk("add_ex_rt_addr", ex_rt_addr, 5'd4);
    chk("add_ex_funct", ex_funct, 6'h20);
    chk("add_ex_valid", ex_valid, 1'b1);

    // lw $2 ; beq $2,$5 -> two stalls
    set_id(C_LW, 1'b1, 5'd1, 5'd2, 5'd0, 6'd0);
    chk("lw_beq_nostall0", stall, 1'b0);
    step();
    set_id(C_BEQ, 1'b1, 5'd2, 5'd5, 5'd0, 6'd0);
    chk("lw_beq_stall1", stall, 1'b1);
    step();
    chk("lw_beq_stall2", stall, 1'b1);
    chk("lw_beq_bubble1", ex_ctrl, 8'h00);
    step();
    chk("lw_beq_stall_end", stall, 1'b0);
    chk("lw_beq_bubble2", ex_valid, 1'b0);
    chk("lw_beq_count", stall_count, 16'd3);
    step();
    chk("beq_ex_ctrl", ex_ctrl, C_BEQ);
    chk("beq_ex_valid", ex_valid, 1'b1);

    // addi $2,$0,5 ; beq $2,$0 -> one stall
    set_id(C_ADDI, 1'b1, 5'd0, 5'd2, 5'd0, 6'd0);
    chk("addi_nostall", stall, 1'b0);
    step();
    set_id(C_BEQ, 1'b1, 5'd2, 5'd0, 5'd0, 6'd0);
    chk("addi_beq_stall", stall, 1'b1);
    step();
    chk("addi_beq_stall_end", stall, 1'b0);
    chk("addi_beq_count", stall_count, 16'd4);
    step();

    // add $2 ; sw $2,0($6) -> no stall
    set_id(C_ADD, 1'b1, 5'd7, 5'd8, 5'd2, 6'h20);
    step();
    set_id(C_SW, 1'b1, 5'd6, 5'd2, 5'd0, 6'd0);
    chk("add_sw_ex_dest", ex_dest, 5'd2);
    chk("add_sw_nostall", stall, 1'b0);
    step();

    // lw $0 ; add $3,$0,$0 -> no stall
    set_id(C_LW, 1'b1, 5'd1, 5'd0, 5'd0, 6'd0);
    step();
    set_id(C_ADD, 1'b1, 5'd0, 5'd0, 5'd3, 6'h20);
    chk("lw0_nostall", stall, 1'b0);
    step();

    // invalid instruction behind a load -> no stall, ctrl 0 into EX
    set_id(C_LW, 1'b1, 5'd1, 5'd2, 5'd0, 6'd0);
    step();
    set_id(C_ADD, 1'b0, 5'd2, 5'd2, 5'd4, 6'h20);
    chk("invalid_nostall", stall, 1'b0);
    step();
    chk("invalid_ex_ctrl", ex_ctrl, 8'h00);
    chk("invalid_ex_valid", ex_valid, 1'b0);
    chk("invalid_count", stall_count, 16'd4);

    // Reset during the second LW->BEQ stall
    set_id(C_LW, 1'b1, 5'd1, 5'd2, 5'd0, 6'd0);
    step();
    set_id(C_BEQ, 1'b1, 5'd2, 5'd5, 5'd0, 6'd0);
    step();
    chk("pre_rst_stall", stall, 1'b1);
    chk("pre_rst_count", stall_count, 16'd5);
    #2 rst = 1'b1;
    #2;
    chk("async_rst_ctrl", ex_ctrl, 8'h00);
    chk("async_rst_count", stall_count, 16'd0);
    chk("async_rst_stall", stall, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", stall, 1'b0);
    step();
    chk("post_rst_beq_ctrl", ex_ctrl, C_BEQ);
    chk("post_rst_beq_valid", ex_valid, 1'b1);
    chk("post_rst_count", stall_count, 16'd0);

    // Saturation: each lw/beq pair adds two stall cycles
    for (int unsigned i = 0; i < 32770; i++) begin
      set_id(C_LW, 1'b1, 5'd1, 5'd2, 5'd0, 6'd0);
      step();
      set_id(C_BEQ, 1'b1, 5'd2, 5'd5, 5'd0, 6'd0);
      step();
      step();
      if (i == 32766) chk("sat_near", stall_count, 16'hFFFE);
    end
    chk("sat_hold", stall_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
